// File: rtl/seq_mult32.sv
// seq_mult32: unsigned 32x32 -> 64 shift-and-add multiplier.
// One iteration per clock. A fixed 32 iterations run per operation, with no
// early exit. Each iteration does one add through a 32-bit ripple-carry
// adder, then shifts {C,A,Q} right by one bit.
//
// Handshake: start is only looked at on an accepting edge. That is an edge
// where the FSM is in IDLE, or the DONE->IDLE exit edge, so that operations
// can issue back to back every 33 cycles. On that edge a and b are captured.
// Thirty-two edges later the product register is loaded and done pulses for
// exactly one cycle. start, a and b are ignored on every other edge.
// busy, done and product come straight from registers or decoded state.

// Ripple-carry adder: explicit full-adder chain, carry-in tied to zero.
module seq_mult32_rca (
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    logic [32:0] carry;

    // Carry chain seed; the adder never takes a carry-in.
    always_comb begin
        carry[0] = 1'b0;
    end

    genvar i;
    generate
        for (i = 0; i < 32; i = i + 1) begin : g_fa
            // One full adder per bit; carry ripples from bit 0 upwards.
            always_comb begin
                sum_o[i]   = x_i[i] ^ y_i[i] ^ carry[i];
                carry[i+1] = (x_i[i] & y_i[i]) | (carry[i] & (x_i[i] ^ y_i[i]));
            end
        end
    endgenerate

    // Final carry-out becomes the C bit of the iteration.
    always_comb begin
        cout_o = carry[32];
    end
endmodule

module seq_mult32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [1:0]  dbg_state,
    output logic [5:0]  dbg_cnt,
    output logic        dbg_carry
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] q_q, q_d;
    logic        c_q, c_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] product_q, product_d;

    logic [31:0] addend;
    logic [31:0] add_sum;
    logic        add_cout;
    logic [31:0] acc_shift;
    logic [31:0] q_shift;
    logic        last_iter;
    logic        accept;

    // Multiplicand is added only when the current multiplier LSB is set.
    always_comb begin
        addend = q_q[0] ? m_q : 32'd0;
    end

    seq_mult32_rca u_rca (
        .x_i    (acc_q),
        .y_i    (addend),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Right shift of {C,A,Q} after the add. The carry drops into A's MSB,
    // A's LSB drops into Q's MSB, and C itself becomes zero.
    always_comb begin
        acc_shift = {add_cout, add_sum[31:1]};
        q_shift   = {add_sum[0], q_q[31:1]};
        last_iter = (cnt_q == 6'd31);
    end

    // An operation can be accepted from IDLE or on the DONE exit edge.
    always_comb begin
        accept = start && ((state_q == IDLE) || (state_q == DONE));
    end

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_shift;
                q_d   = q_shift;
                c_d   = 1'b0;
                cnt_d = cnt_q + 6'd1;
                if (last_iter) begin
                    product_d = {acc_shift, q_shift};
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = accept ? CALC : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operand capture is common to both accepting states.
        if (accept) begin
            m_d   = a;
            q_d   = b;
            acc_d = 32'd0;
            c_d   = 1'b0;
            cnt_d = 6'd0;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= 32'd0;
            acc_q     <= 32'd0;
            q_q       <= 32'd0;
            c_q       <= 1'b0;
            cnt_q     <= 6'd0;
            product_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy      = (state_q == CALC);
        done      = (state_q == DONE);
        product   = product_q;
        dbg_state = state_q;
        dbg_cnt   = cnt_q;
        dbg_carry = c_q;
    end
endmodule

// File: tb/tb_seq_mult32.sv
// Testbench for seq_mult32.
// The reference is plain 64-bit multiplication plus the timing rules:
// - A start accepted at edge k gives busy after edges k..k+31.
// - done follows edge k+32.
// - product holds the last completed result, and reset clears it.
// Stimulus pushes expected results after the accepting edge. A negedge
// monitor pops and compares.
module tb_seq_mult32;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [1:0]  dbg_state;
  logic [5:0]  dbg_cnt;
  logic        dbg_carry;

  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [63:0] exp_q[$];
  int          edge_q[$];
  logic [63:0] hold;
  bit          end_req;
  bit          end_ack;

  seq_mult32 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a_in),
    .b         (b_in),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt),
    .dbg_carry (dbg_carry)
  );

  // clock / edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    bit exp_busy;
    bit exp_done;
    if (rst) begin
      exp_q.delete();
      edge_q.delete();
      hold = 64'd0;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_product", product, 64'd0);
      chk("rst_carry", {63'd0, dbg_carry}, 64'd0);
    end else begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (edge_q.size() > 0) begin
        exp_busy = (cyc >= edge_q[0] - 32) && (cyc < edge_q[0]);
        exp_done = (cyc == edge_q[0]);
      end
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("done", {63'd0, done}, {63'd0, exp_done});
      if (exp_done) begin
        hold = exp_q.pop_front();
        void'(edge_q.pop_front());
      end
      chk("product", product, hold);
    end
    if (end_req && !end_ack) begin
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      end_ack = 1'b1;
    end
  end

  // driver: call just after a negedge; accepting edge is the next posedge
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    int acc;
    start = 1'b1;
    a_in  = x;
    b_in  = y;
    acc   = cyc + 1;
    @(posedge clk);
    #1;
    exp_q.push_back({32'd0, x} * {32'd0, y});
    edge_q.push_back(acc + 32);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  // run through the 32 CALC edges, optionally toggling start/a/b; ends at negedge k+32
  task automatic run_calc(input bit glitch);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (glitch) begin
        start = 1'($urandom_range(0, 1));
        a_in  = $urandom;
        b_in  = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    end_req  = 1'b0;
    end_ack  = 1'b0;
    hold     = 64'd0;
    rst      = 1'b1;
    start    = 1'b0;
    a_in     = 32'd0;
    b_in     = 32'd0;
    repeat (3) @(negedge clk);

    // start held through reset is taken on the first edge after release: 3*5
    start = 1'b1;
    a_in  = 32'd3;
    b_in  = 32'd5;
    @(posedge clk);
    #1 rst = 1'b0;
    start_op(32'd3, 32'd5);
    run_calc(1'b0);
    repeat (2) @(negedge clk);

    // carry on every add, zero operand, pure shift
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_calc(1'b0);
    @(negedge clk);
    start_op(32'd0, 32'h1234_5678);
    run_calc(1'b0);
    @(negedge clk);
    start_op(32'h8000_0000, 32'd2);
    run_calc(1'b0);
    repeat (3) @(negedge clk);

    // start reasserted at edge k+10 with 9*9 is ignored
    start_op(32'd7, 32'd6);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      start = (i == 9);
      a_in  = (i == 9) ? 32'd9 : 32'd0;
      b_in  = (i == 9) ? 32'd9 : 32'd0;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // back-to-back: second start on the DONE exit edge
    start_op(32'd2, 32'd3);
    run_calc(1'b0);
    start_op(32'd4, 32'd5);
    run_calc(1'b0);
    @(negedge clk);

    // reset in the middle of an operation, then silence
    start_op(32'h0000_FFFF, 32'h0000_FFFF);
    repeat (15) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);

    // randomized operations with start/a/b noise while busy
    for (int n = 0; n < 24; n++) begin
      start_op(pick_operand(), pick_operand());
      run_calc(1'b1);
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end

    // drain, bounded
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    end_req = 1'b1;
    for (int t = 0; t < 10 && !end_ack; t++) @(negedge clk);
    if (!end_ack) $display("FAIL end_handshake: got no ack expected ack");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, (end_ack ? n_fail : n_fail + 1));
    $finish;
  end
endmodule
